// File: rtl/divide_controller_pkg.sv
// Shared types and constants for the divide controller and its iterative divider.
// Provides cpu_data_t, divider/controller state enums and the divide-by-zero result.
package divide_controller_pkg;

    localparam int CPU_DATA_WIDTH = 32;

    typedef logic [CPU_DATA_WIDTH-1:0] cpu_data_t;

    typedef enum logic {
        DIV_IDLE,
        DIV_RUN
    } divide_state_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        DRAIN,
        DONE
    } div_ctrl_state_t;

    localparam cpu_data_t DIV_BY_ZERO_LO = 32'hFFFF_FFFF;
    localparam int DIV_STEPS = CPU_DATA_WIDTH;
    localparam int DIV_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/divide_controller_divider.sv
// Non-abortable radix-2 restoring divider, one quotient bit per cycle.
// Ports: clock, reset (sync, active-high); i_request_valid, i_signed,
//   i_dividend, i_divisor in; o_result_valid (1-cycle pulse), o_result
//   (quotient), o_remain (remainder) out. Requests while busy are ignored.
module divide_controller_divider
    import divide_controller_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      i_request_valid,
    input  logic      i_signed,
    input  cpu_data_t i_dividend,
    input  cpu_data_t i_divisor,
    output logic      o_result_valid,
    output cpu_data_t o_result,
    output cpu_data_t o_remain
);

    localparam int CNT_W = $clog2(DIV_STEPS + 1);

    divide_state_t    r_state;
    logic [CNT_W-1:0] r_count;
    cpu_data_t        r_quo;
    cpu_data_t        r_rem;
    cpu_data_t        r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;

    logic                    w_a_neg;
    logic                    w_b_neg;
    cpu_data_t               w_a_abs;
    cpu_data_t               w_b_abs;
    logic [CPU_DATA_WIDTH:0] w_shift;
    logic                    w_ge;
    cpu_data_t               w_rem_next;
    cpu_data_t               w_quo_next;

    assign w_a_neg = i_signed & i_dividend[CPU_DATA_WIDTH-1];
    assign w_b_neg = i_signed & i_divisor[CPU_DATA_WIDTH-1];
    assign w_a_abs = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_abs = w_b_neg ? -i_divisor : i_divisor;

    // Partial remainder stays below the divisor, so the shifted value
    // needs one extra bit; the difference always fits the data width.
    assign w_shift    = {r_rem, r_quo[CPU_DATA_WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[CPU_DATA_WIDTH-1:0] - r_dvs)
                             : w_shift[CPU_DATA_WIDTH-1:0];
    assign w_quo_next = {r_quo[CPU_DATA_WIDTH-2:0], w_ge};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= DIV_IDLE;
            r_count        <= '0;
            r_quo          <= '0;
            r_rem          <= '0;
            r_dvs          <= '0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            o_result_valid <= 1'b0;
            o_result       <= '0;
            o_remain       <= '0;
        end else begin
            o_result_valid <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (i_request_valid) begin
                        r_state <= DIV_RUN;
                        r_count <= CNT_W'(DIV_STEPS);
                        r_quo   <= w_a_abs;
                        r_rem   <= '0;
                        r_dvs   <= w_b_abs;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                    end
                end
                DIV_RUN: begin
                    r_quo   <= w_quo_next;
                    r_rem   <= w_rem_next;
                    r_count <= r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        r_state        <= DIV_IDLE;
                        o_result_valid <= 1'b1;
                        o_result       <= r_neg_q ? -w_quo_next : w_quo_next;
                        o_remain       <= r_neg_r ? -w_rem_next : w_rem_next;
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/divide_controller.sv
// Sequences the iterative divider for DIV/DIVU in execute: stalls until done, writes HI/LO.
// Ports: clock, reset (sync, active-high); ex_div_valid, ex_div_signed, ex_src1,
//   ex_src2, ex_flush in; ex_div_stall, hilo_we, hi_wdata (remainder),
//   lo_wdata (quotient), div_busy, timeout_error (sticky) out.
module divide_controller
    import divide_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DIV_TIMEOUT_CYCLES
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      ex_div_valid,
    input  logic      ex_div_signed,
    input  cpu_data_t ex_src1,
    input  cpu_data_t ex_src2,
    input  logic      ex_flush,
    output logic      ex_div_stall,
    output logic      hilo_we,
    output cpu_data_t hi_wdata,
    output cpu_data_t lo_wdata,
    output logic      div_busy,
    output logic      timeout_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    div_ctrl_state_t r_state;
    div_ctrl_state_t w_next_state;

    logic          r_signed;
    cpu_data_t     r_src1;
    cpu_data_t     r_src2;
    cpu_data_t     r_hi;
    cpu_data_t     r_lo;
    logic [CW-1:0] r_count;
    logic          r_timeout;

    logic      w_div_req;
    logic      w_div_rv;
    cpu_data_t w_div_result;
    cpu_data_t w_div_remain;

    logic w_waiting;
    logic w_timeout;
    logic w_accept;
    logic w_zero;
    logic w_capture;
    logic w_wd_fire;

    divide_controller_divider u_divider (
        .clock          (clock),
        .reset          (reset),
        .i_request_valid(w_div_req),
        .i_signed       (r_signed),
        .i_dividend     (r_src1),
        .i_divisor      (r_src2),
        .o_result_valid (w_div_rv),
        .o_result       (w_div_result),
        .o_remain       (w_div_remain)
    );

    assign w_waiting = (r_state == BUSY) || (r_state == DRAIN);
    assign w_timeout = w_waiting && (r_count >= CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_zero       = 1'b0;
        w_capture    = 1'b0;
        w_wd_fire    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (ex_div_valid && !ex_flush) begin
                    if (ex_src2 != '0) begin
                        w_accept     = 1'b1;
                        w_next_state = ISSUE;
                    end else begin
                        w_zero       = 1'b1;
                        w_next_state = DONE;
                    end
                end
            end
            // The request already went out this cycle, so a flush must drain.
            ISSUE: w_next_state = ex_flush ? DRAIN : BUSY;
            BUSY: begin
                if (w_div_rv) begin
                    if (ex_flush) begin
                        w_next_state = IDLE;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = DONE;
                    end
                end else if (w_timeout) begin
                    w_wd_fire    = 1'b1;
                    w_next_state = IDLE;
                end else if (ex_flush) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_div_rv) begin
                    w_next_state = IDLE;
                end else if (w_timeout) begin
                    w_wd_fire    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_signed  <= 1'b0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_signed <= ex_div_signed;
                r_src1   <= ex_src1;
                r_src2   <= ex_src2;
            end
            if (w_zero) begin
                r_hi <= ex_src1;
                r_lo <= DIV_BY_ZERO_LO;
            end
            if (w_capture) begin
                r_hi <= w_div_remain;
                r_lo <= w_div_result;
            end
            if (w_accept) begin
                r_count <= '0;
            end else if (w_waiting) begin
                r_count <= r_count + 1'b1;
            end
            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_div_req     = (r_state == ISSUE);
    assign hilo_we       = (r_state == DONE) && !ex_flush;
    assign ex_div_stall  = ex_div_valid && !ex_flush && (r_state != DONE);
    assign div_busy      = w_waiting;
    assign hi_wdata      = r_hi;
    assign lo_wdata      = r_lo;
    assign timeout_error = r_timeout;

endmodule
